// File: rtl/ahb_shared_mem_arbiter.sv
// Two-master (fetch/load-store) to one-slave AHB-Lite arbiter for a shared single-ported SRAM.
// Losing address phases are parked in a per-master holding register; D has priority with a streak cap.
module ahb_shared_mem_arbiter #(
    parameter int unsigned D_STREAK_MAX = 4,
    parameter int unsigned AW           = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    // Instruction-fetch master
    input  logic [AW-1:0] i_haddr,
    input  logic [1:0]    i_htrans,
    input  logic [2:0]    i_hsize,
    output logic          i_hready,
    output logic [31:0]   i_hrdata,
    // Load/store master
    input  logic [AW-1:0] d_haddr,
    input  logic [1:0]    d_htrans,
    input  logic          d_hwrite,
    input  logic [2:0]    d_hsize,
    input  logic [31:0]   d_hwdata,
    output logic          d_hready,
    output logic [31:0]   d_hrdata,
    // Shared memory slave
    output logic [AW-1:0] s_haddr,
    output logic [1:0]    s_htrans,
    output logic          s_hwrite,
    output logic [2:0]    s_hsize,
    output logic [31:0]   s_hwdata,
    input  logic [31:0]   s_hrdata,
    input  logic          s_hready
);

    localparam int unsigned StreakW = $clog2(D_STREAK_MAX + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(D_STREAK_MAX);
    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransNonseq = 2'b10;

    typedef enum logic [1:0] {OwnNone, OwnI, OwnD} owner_e;

    owner_e              dp_owner_q, dp_owner_d;
    logic                pend_i_q, pend_i_d;
    logic                pend_d_q, pend_d_d;
    logic [AW-1:0]       i_addr_q, i_addr_d;
    logic [2:0]          i_size_q, i_size_d;
    logic [AW-1:0]       d_addr_q, d_addr_d;
    logic [2:0]          d_size_q, d_size_d;
    logic                d_write_q, d_write_d;
    logic [StreakW-1:0]  d_streak_q, d_streak_d;
    logic [AW-1:0]       last_addr_q, last_addr_d;
    logic [2:0]          last_size_q, last_size_d;
    logic                last_write_q, last_write_d;

    logic          acc_i, acc_d, req_i, req_d, gnt_i, gnt_d;
    logic [AW-1:0] src_i_addr, src_d_addr;
    logic [2:0]    src_i_size, src_d_size;
    logic          src_d_write;

    // htrans[0] (SEQ vs NONSEQ) is irrelevant: every issued transfer becomes NONSEQ.
    logic unused_htrans;
    assign unused_htrans = i_htrans[0] ^ d_htrans[0];

    assign i_hrdata = s_hrdata;
    assign d_hrdata = s_hrdata;

    always_comb begin
        i_hready = 1'b1;
        if (pend_i_q) begin
            i_hready = 1'b0;
        end else if (dp_owner_q == OwnI) begin
            i_hready = s_hready;
        end
        d_hready = 1'b1;
        if (pend_d_q) begin
            d_hready = 1'b0;
        end else if (dp_owner_q == OwnD) begin
            d_hready = s_hready;
        end

        acc_i = i_hready & i_htrans[1];
        acc_d = d_hready & d_htrans[1];
        req_i = pend_i_q | acc_i;
        req_d = pend_d_q | acc_d;

        src_i_addr  = pend_i_q ? i_addr_q  : i_haddr;
        src_i_size  = pend_i_q ? i_size_q  : i_hsize;
        src_d_addr  = pend_d_q ? d_addr_q  : d_haddr;
        src_d_size  = pend_d_q ? d_size_q  : d_hsize;
        src_d_write = pend_d_q ? d_write_q : d_hwrite;

        gnt_i = s_hready & req_i & ((d_streak_q == StreakMax) | ~req_d);
        gnt_d = s_hready & req_d & ~gnt_i;

        s_htrans = HtransIdle;
        s_haddr  = last_addr_q;
        s_hsize  = last_size_q;
        s_hwrite = last_write_q;
        if (gnt_d) begin
            s_htrans = HtransNonseq;
            s_haddr  = src_d_addr;
            s_hsize  = src_d_size;
            s_hwrite = src_d_write;
        end else if (gnt_i) begin
            s_htrans = HtransNonseq;
            s_haddr  = src_i_addr;
            s_hsize  = src_i_size;
            s_hwrite = 1'b0;
        end
        s_hwdata = (dp_owner_q == OwnD) ? d_hwdata : 32'h0;

        last_addr_d  = s_haddr;
        last_size_d  = s_hsize;
        last_write_d = s_hwrite;

        pend_i_d = pend_i_q;
        i_addr_d = i_addr_q;
        i_size_d = i_size_q;
        if (acc_i && !gnt_i) begin
            pend_i_d = 1'b1;
            i_addr_d = i_haddr;
            i_size_d = i_hsize;
        end else if (gnt_i) begin
            pend_i_d = 1'b0;
        end

        pend_d_d  = pend_d_q;
        d_addr_d  = d_addr_q;
        d_size_d  = d_size_q;
        d_write_d = d_write_q;
        if (acc_d && !gnt_d) begin
            pend_d_d  = 1'b1;
            d_addr_d  = d_haddr;
            d_size_d  = d_hsize;
            d_write_d = d_hwrite;
        end else if (gnt_d) begin
            pend_d_d = 1'b0;
        end

        // Ownership only moves when the current data phase completes.
        dp_owner_d = dp_owner_q;
        if (s_hready) begin
            if (gnt_d) begin
                dp_owner_d = OwnD;
            end else if (gnt_i) begin
                dp_owner_d = OwnI;
            end else begin
                dp_owner_d = OwnNone;
            end
        end

        d_streak_d = d_streak_q;
        if (gnt_i || !req_i) begin
            d_streak_d = '0;
        end else if (gnt_d && d_streak_q != StreakMax) begin
            d_streak_d = d_streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dp_owner_q   <= OwnNone;
            pend_i_q     <= 1'b0;
            pend_d_q     <= 1'b0;
            i_addr_q     <= '0;
            i_size_q     <= '0;
            d_addr_q     <= '0;
            d_size_q     <= '0;
            d_write_q    <= 1'b0;
            d_streak_q   <= '0;
            last_addr_q  <= '0;
            last_size_q  <= '0;
            last_write_q <= 1'b0;
        end else begin
            dp_owner_q   <= dp_owner_d;
            pend_i_q     <= pend_i_d;
            pend_d_q     <= pend_d_d;
            i_addr_q     <= i_addr_d;
            i_size_q     <= i_size_d;
            d_addr_q     <= d_addr_d;
            d_size_q     <= d_size_d;
            d_write_q    <= d_write_d;
            d_streak_q   <= d_streak_d;
            last_addr_q  <= last_addr_d;
            last_size_q  <= last_size_d;
            last_write_q <= last_write_d;
        end
    end

endmodule

// File: tb/tb_ahb_shared_mem_arbiter.sv
// Scoreboard bench: expected slave transfers are queued as stimulus is driven and matched
// against the slave port; data phases are checked by a small slave model.
module tb_ahb_shared_mem_arbiter;

    localparam logic [31:0] Key = 32'h5A5A_0F0F;

    typedef struct packed {
        logic        is_d;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_haddr, d_haddr, s_haddr;
    logic [1:0]  i_htrans, d_htrans, s_htrans;
    logic [2:0]  i_hsize, d_hsize, s_hsize;
    logic        i_hready, d_hready, s_hready, d_hwrite, s_hwrite;
    logic [31:0] i_hrdata, d_hrdata, d_hwdata, s_hwdata, s_hrdata;

    int    n_vec = 0;
    int    n_err = 0;
    xfer_t exp_q[$];
    xfer_t dp_x, nxt_x, pop_x;
    logic  dp_valid, nxt_valid;
    logic [7:0] ei, ed;

    always #5 clk = ~clk;

    ahb_shared_mem_arbiter #(.D_STREAK_MAX(4), .AW(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_haddr  (i_haddr),
        .i_htrans (i_htrans),
        .i_hsize  (i_hsize),
        .i_hready (i_hready),
        .i_hrdata (i_hrdata),
        .d_haddr  (d_haddr),
        .d_htrans (d_htrans),
        .d_hwrite (d_hwrite),
        .d_hsize  (d_hsize),
        .d_hwdata (d_hwdata),
        .d_hready (d_hready),
        .d_hrdata (d_hrdata),
        .s_haddr  (s_haddr),
        .s_htrans (s_htrans),
        .s_hwrite (s_hwrite),
        .s_hsize  (s_hsize),
        .s_hwdata (s_hwdata),
        .s_hrdata (s_hrdata),
        .s_hready (s_hready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic is_d, input logic [31:0] a, input logic w,
                        input logic [2:0] sz, input logic [31:0] wd);
        xfer_t x;
        x.is_d = is_d; x.addr = a; x.wr = w; x.sz = sz; x.wdata = wd;
        exp_q.push_back(x);
    endtask

    task automatic idle_all();
        i_htrans = 2'b00; d_htrans = 2'b00;
    endtask

    task automatic i_req(input logic [31:0] a, input logic [1:0] t);
        i_haddr = a; i_htrans = t; i_hsize = 3'd2;
    endtask

    task automatic d_req(input logic [31:0] a, input logic [1:0] t, input logic w,
                         input logic [2:0] sz);
        d_haddr = a; d_htrans = t; d_hwrite = w; d_hsize = sz;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Slave model: read data is a function of the data-phase address.
    assign s_hrdata = dp_valid ? (dp_x.addr ^ Key) : 32'h0;

    always @(posedge clk) begin
        if (!rst_n) begin
            dp_valid <= 1'b0;
        end else if (s_hready) begin
            dp_valid <= nxt_valid;
            dp_x     <= nxt_x;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (dp_valid && s_hready) begin
                if (dp_x.wr) begin
                    check("dp_wdata", s_hwdata, dp_x.wdata);
                end else if (dp_x.is_d) begin
                    check("dp_d_rdata", d_hrdata, dp_x.addr ^ Key);
                end else begin
                    check("dp_i_rdata", i_hrdata, dp_x.addr ^ Key);
                    check("dp_i_wdata0", s_hwdata, 32'h0);
                end
            end
            nxt_valid = 1'b0;
            if (!s_hready) begin
                check("wait_idle", 32'(s_htrans), 32'h0);
            end else if (s_htrans != 2'b00) begin
                check("sb_avail", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    pop_x = exp_q.pop_front();
                    check("s_htrans", 32'(s_htrans), 32'h2);
                    check("s_haddr", s_haddr, pop_x.addr);
                    check("s_hwrite", 32'(s_hwrite), 32'(pop_x.wr));
                    check("s_hsize", 32'(s_hsize), 32'(pop_x.sz));
                    nxt_valid = 1'b1;
                    nxt_x     = pop_x;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; s_hready = 1'b1;
        i_haddr = '0; i_htrans = '0; i_hsize = '0;
        d_haddr = '0; d_htrans = '0; d_hwrite = 1'b0; d_hsize = '0; d_hwdata = '0;
        nxt_valid = 1'b0;
        ei = 8'b1110_0001;
        ed = 8'b1101_1111;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_htrans", 32'(s_htrans), 32'h0);
        check("rst_haddr", s_haddr, 32'h0);
        check("rst_hsize", 32'(s_hsize), 32'h0);
        check("rst_hwrite", 32'(s_hwrite), 32'h0);
        check("rst_hwdata", s_hwdata, 32'h0);
        check("rst_irdy", 32'(i_hready), 32'h1);
        check("rst_drdy", 32'(d_hready), 32'h1);
        nxt();

        // Lone fetches, second one SEQ
        i_req(32'h0, 2'b10); push(1'b0, 32'h0, 1'b0, 3'd2, 32'h0);
        @(negedge clk);
        check("t2_irdy0", 32'(i_hready), 32'h1);
        nxt();
        i_req(32'h4, 2'b11); push(1'b0, 32'h4, 1'b0, 3'd2, 32'h0);
        @(negedge clk);
        check("t2_irdy1", 32'(i_hready), 32'h1);
        nxt();
        idle_all();
        @(negedge clk);
        check("t2_irdy2", 32'(i_hready), 32'h1);
        check("t2_streak", 32'(dut.d_streak_q), 32'h0);
        nxt();

        // Simultaneous I read and D store: D first, I buffered
        i_req(32'h100, 2'b10); d_req(32'h200, 2'b10, 1'b1, 3'd2);
        push(1'b1, 32'h200, 1'b1, 3'd2, 32'hDEAD_BEEF);
        push(1'b0, 32'h100, 1'b0, 3'd2, 32'h0);
        @(negedge clk);
        check("t3_irdy0", 32'(i_hready), 32'h1);
        check("t3_drdy0", 32'(d_hready), 32'h1);
        nxt();
        idle_all(); d_hwdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t3_irdy1", 32'(i_hready), 32'h0);
        check("t3_drdy1", 32'(d_hready), 32'h1);
        nxt();
        d_hwdata = 32'h0;
        @(negedge clk);
        check("t3_irdy2", 32'(i_hready), 32'h1);
        nxt();

        // D streak cap: four D grants, then the waiting fetch, then D resumes
        for (int k = 0; k < 4; k++) push(1'b1, 32'h1000 + 32'(4 * k), 1'b0, 3'd2, 32'h0);
        push(1'b0, 32'h300, 1'b0, 3'd2, 32'h0);
        push(1'b1, 32'h1010, 1'b0, 3'd2, 32'h0);
        push(1'b1, 32'h1014, 1'b0, 3'd2, 32'h0);
        for (int c = 0; c < 8; c++) begin
            idle_all();
            if (c == 0) i_req(32'h300, 2'b10);
            if (c <= 4) d_req(32'h1000 + 32'(4 * c), 2'b10, 1'b0, 3'd2);
            if (c == 5 || c == 6) d_req(32'h1014, 2'b10, 1'b0, 3'd2);
            @(negedge clk);
            check("t4_irdy", 32'(i_hready), 32'(ei[c]));
            check("t4_drdy", 32'(d_hready), 32'(ed[c]));
            if (c == 4) check("t4_streak_max", 32'(dut.d_streak_q), 32'd4);
            if (c == 7) check("t4_streak_clr", 32'(dut.d_streak_q), 32'd0);
            nxt();
        end

        // Wait states on a D load while a fetch arrives
        push(1'b1, 32'h2000, 1'b0, 3'd2, 32'h0);
        push(1'b0, 32'h400, 1'b0, 3'd2, 32'h0);
        d_req(32'h2000, 2'b10, 1'b0, 3'd2);
        @(negedge clk);
        check("t5_drdy0", 32'(d_hready), 32'h1);
        nxt();
        idle_all(); s_hready = 1'b0; i_req(32'h400, 2'b10);
        @(negedge clk);
        check("t5_irdy1", 32'(i_hready), 32'h1);
        check("t5_drdy1", 32'(d_hready), 32'h0);
        nxt();
        idle_all();
        @(negedge clk);
        check("t5_irdy2", 32'(i_hready), 32'h0);
        check("t5_drdy2", 32'(d_hready), 32'h0);
        check("t5_pend_i", 32'(dut.pend_i_q), 32'h1);
        nxt();
        s_hready = 1'b1;
        @(negedge clk);
        check("t5_addr3", s_haddr, 32'h400);
        check("t5_irdy3", 32'(i_hready), 32'h0);
        check("t5_drdy3", 32'(d_hready), 32'h1);
        nxt();
        @(negedge clk);
        check("t5_irdy4", 32'(i_hready), 32'h1);
        nxt();

        // Held D store (presented as SEQ) reproduced from the holding register
        push(1'b0, 32'h500, 1'b0, 3'd2, 32'h0);
        push(1'b1, 32'h3008, 1'b1, 3'd1, 32'hCAFE_F00D);
        i_req(32'h500, 2'b10);
        nxt();
        idle_all(); s_hready = 1'b0; d_req(32'h3008, 2'b11, 1'b1, 3'd1);
        @(negedge clk);
        check("t6_drdy1", 32'(d_hready), 32'h1);
        check("t6_irdy1", 32'(i_hready), 32'h0);
        check("t6_addr_hold", s_haddr, 32'h500);
        nxt();
        s_hready = 1'b1; d_req(32'hFFFF_FFFC, 2'b00, 1'b0, 3'd0); d_hwdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("t6_drdy2", 32'(d_hready), 32'h0);
        nxt();
        @(negedge clk);
        check("t6_drdy3", 32'(d_hready), 32'h1);
        nxt();
        d_hwdata = 32'h0;

        // Reset mid-data-phase with a fetch pending
        push(1'b1, 32'h2200, 1'b0, 3'd2, 32'h0);
        d_req(32'h2200, 2'b10, 1'b0, 3'd2);
        nxt();
        idle_all(); s_hready = 1'b0; i_req(32'h700, 2'b10);
        @(negedge clk);
        check("t7_irdy1", 32'(i_hready), 32'h1);
        nxt();
        idle_all(); rst_n = 1'b0;
        @(negedge clk);
        check("t7_pend_pre", 32'(dut.pend_i_q), 32'h1);
        nxt();
        rst_n = 1'b1; s_hready = 1'b1;
        @(negedge clk);
        check("t7_htrans", 32'(s_htrans), 32'h0);
        check("t7_haddr", s_haddr, 32'h0);
        check("t7_irdy", 32'(i_hready), 32'h1);
        check("t7_drdy", 32'(d_hready), 32'h1);
        check("t7_pend_i", 32'(dut.pend_i_q), 32'h0);
        check("t7_pend_d", 32'(dut.pend_d_q), 32'h0);
        check("t7_owner", 32'(dut.dp_owner_q), 32'h0);
        nxt();
        nxt();

        check("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
